// File: rtl/ising_anneal_ctrl_pkg.sv
// Shared constants, state encoding and payload types for the Ising anneal sequencer.
// Holds the weight geometry, the neutral weight level and the pair-index mapping.
package ising_anneal_ctrl_pkg;

    localparam int unsigned N             = 3;
    localparam int unsigned NUM_WEIGHTS   = 5;
    localparam int unsigned RESET_CYCLES  = 16;
    localparam int unsigned RUN_W         = 16;
    localparam int unsigned SAMPLE_CYCLES = 64;

    localparam int unsigned WBITS     = $clog2(NUM_WEIGHTS);
    localparam int unsigned NPAIR     = N * (N - 1) / 2;
    localparam int unsigned PAIR_AW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int unsigned VCNT_W    = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned CNT_W     = RUN_W + 2;
    localparam int unsigned NEUTRAL_W = NUM_WEIGHTS / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [PAIR_AW-1:0] addr;
        logic [WBITS-1:0]   data;
    } cfg_word_t;

    // Upper-triangle row-major index of pair (i,j), i<j.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
        return i * (2 * N - i - 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/ising_anneal_ctrl_if.sv
// Host-side bus of the anneal sequencer: weight config, run start/busy and result handshake.
interface ising_anneal_ctrl_if;
    import ising_anneal_ctrl_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [PAIR_AW-1:0] cfg_addr;
    logic [WBITS-1:0]   cfg_data;
    logic               start;
    logic [RUN_W-1:0]   run_cycles;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [N-1:0]       res_spins;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, start, run_cycles, res_ready,
        input  cfg_ready, busy, res_valid, res_spins
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, start, run_cycles, res_ready,
        output cfg_ready, busy, res_valid, res_spins
    );

endinterface

// File: rtl/ising_phase_vote.sv
// Per-spin phase vote: counts sample cycles where a differs from the reference spin
// and reports anti-phase when the count exceeds half the window (ties vote in-phase).
module ising_phase_vote
    import ising_anneal_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic a,
    input  logic base,
    output logic vote
);

    logic [VCNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (a != base)) begin
            count <= count + VCNT_W'(1);
        end
    end

    assign vote = (count > VCNT_W'(SAMPLE_CYCLES / 2));

endmodule

// File: rtl/ising_anneal_ctrl.sv
// Run sequencer for the coupled-oscillator Ising array: weight registers, array reset,
// one anneal per start. Define ISING_SYNC_EN to add a 2-flop synchronizer on core_out.
module ising_anneal_ctrl
    import ising_anneal_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    ising_anneal_ctrl_if.slave     bus,
    output logic                   core_rstn,
    output logic [NPAIR*WBITS-1:0] core_weights,
    input  logic [N-1:0]           core_out
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_len;
    logic [N-1:0]     phase_c;
    logic [N-1:0]     votes_c;
    logic             sample_clr_c;
    logic             sample_en_c;
    logic             cfg_wr_c;
    cfg_word_t        cfg_w_c;

`ifdef ISING_SYNC_EN
    // Synchronizer delay is absorbed by stretching RUN so the window sees settled data.
    localparam int unsigned RUN_EXTRA = 2;
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= core_out;
            sync2 <= sync1;
        end
    end

    assign phase_c = sync2;
`else
    localparam int unsigned RUN_EXTRA = 0;
    assign phase_c = core_out;
`endif

    assign cfg_w_c  = '{addr: bus.cfg_addr, data: bus.cfg_data};
    assign cfg_wr_c = bus.cfg_valid && bus.cfg_ready;

    // Counters clear on the edge that enters SAMPLE, and count on every SAMPLE edge.
    always_comb begin
        sample_clr_c = 1'b0;
        sample_en_c  = 1'b0;
        case (state)
            HOLD:    sample_clr_c = (cnt == CNT_W'(RESET_CYCLES - 1)) && (run_len == '0);
            RUN:     sample_clr_c = ((cnt + CNT_W'(1)) == run_len);
            SAMPLE:  sample_en_c  = 1'b1;
            default: sample_clr_c = 1'b0;
        endcase
    end

    assign votes_c[0] = 1'b0;

    for (genvar i = 1; i < N; i++) begin : g_vote
        ising_phase_vote u_vote (
            .clk    (clk),
            .rst    (rst),
            .clear  (sample_clr_c),
            .enable (sample_en_c),
            .a      (phase_c[i]),
            .base   (phase_c[0]),
            .vote   (votes_c[i])
        );
    end

    // Sequencer and all registered host/array outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            run_len       <= '0;
            core_rstn     <= 1'b0;
            core_weights  <= {NPAIR{WBITS'(NEUTRAL_W)}};
            bus.cfg_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_spins <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_wr_c) begin
                        for (int unsigned p = 0; p < NPAIR; p++) begin
                            if (cfg_w_c.addr == PAIR_AW'(p)) begin
                                core_weights[p*WBITS +: WBITS] <= cfg_w_c.data;
                            end
                        end
                    end
                    if (bus.start) begin
                        run_len       <= CNT_W'(bus.run_cycles) + CNT_W'(RUN_EXTRA);
                        cnt           <= '0;
                        state         <= HOLD;
                        bus.cfg_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        cnt       <= '0;
                        core_rstn <= 1'b1;
                        state     <= (run_len == '0) ? SAMPLE : RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if ((cnt + CNT_W'(1)) == run_len) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                        cnt       <= '0;
                        core_rstn <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle latches the votes once the final count has settled.
                    if (!bus.res_valid) begin
                        bus.res_valid <= 1'b1;
                        bus.res_spins <= votes_c;
                    end else if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    core_rstn     <= 1'b0;
                    bus.cfg_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ising_anneal_ctrl.sv
// Self-checking bench for ising_anneal_ctrl with a behavioural oscillator array whose
// phases settle to the Ising ground state of the weights it is driven with.
`timescale 1ns/1ps
module tb_ising_anneal_ctrl;

`ifdef ISING_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [8:0] NEUTRAL = 9'b010_010_010;

    typedef struct {
        logic [2:0] spins;
        int         lat;
        int         c0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_rstn;
    logic [8:0] core_weights;
    logic [2:0] core_out;
    logic [2:0] osc_out;
    logic [2:0] dir_out;
    logic [2:0] phys;
    logic [2:0] noise;
    logic       dir_mode;
    logic       osc;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rel_cnt = 0;
    logic [8:0] shadow;
    bit         prev_v = 1'b0;

    ising_anneal_ctrl_if bus ();

    ising_anneal_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .core_rstn    (core_rstn),
        .core_weights (core_weights),
        .core_out     (core_out)
    );

    // Lowest-energy spin assignment (spin 0 fixed at 0); first found wins on ties.
    function automatic logic [2:0] ground(input logic [8:0] w);
        int best;
        int e;
        int s1;
        int s2;
        logic [1:0] sv;
        logic [2:0] bs;
        best = 1 << 30;
        bs   = 3'b000;
        for (int s = 0; s < 4; s++) begin
            sv = 2'(s);
            s1 = sv[0] ? -1 : 1;
            s2 = sv[1] ? -1 : 1;
            e  = -((int'(w[2:0]) - 2) * s1 + (int'(w[5:3]) - 2) * s2
                   + (int'(w[8:6]) - 2) * s1 * s2);
            if (e < best) begin
                best = e;
                bs   = {sv, 1'b0};
            end
        end
        return bs;
    endfunction

    always #5 clk = ~clk;

    // Oscillator toggles only at even ns, never on a rising clk edge.
    initial begin
        osc   = 1'b0;
        noise = 3'b000;
        #2;
        forever begin
            osc   = ~osc;
            noise = 3'($urandom);
            #6;
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rel_cnt <= core_rstn ? rel_cnt + 1 : 0;
    end

    assign phys     = ground(core_weights);
    assign osc_out  = !core_rstn ? 3'b000 :
                      (rel_cnt < 100) ? noise : {osc ^ phys[2], osc ^ phys[1], osc};
    assign core_out = dir_mode ? dir_out : osc_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: one comparison set per rising res_valid.
    always @(negedge clk) begin
        exp_t e;
        if (bus.res_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result", 32'(bus.res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("res_spins", 32'(bus.res_spins), 32'(e.spins));
                check_eq("latency", 32'(cyc - e.c0), 32'(e.lat));
            end
        end
        prev_v = bus.res_valid;
    end

    task automatic do_write(input logic [1:0] a, input logic [2:0] d);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_data  = d;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        if (a < 2'd3) shadow[int'(a)*3 +: 3] = d;
        check_eq("wgt_write", 32'(core_weights), 32'(shadow));
    endtask

    task automatic run_anneal(input logic [15:0] rc, input logic [2:0] dir_exp,
                              input bit direct, input bit disturb, input int hold_lo,
                              input bit with_wr, input logic [1:0] wa, input logic [2:0] wd);
        int   t;
        bit   stable;
        logic [2:0] snap;
        exp_t e;
        bus.run_cycles = rc;
        bus.start      = 1'b1;
        if (with_wr) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_addr  = wa;
            bus.cfg_data  = wd;
        end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        if (with_wr && wa < 2'd3) shadow[int'(wa)*3 +: 3] = wd;
        check_eq("wgt_at_start", 32'(core_weights), 32'(shadow));
        check_eq("hold_state", 32'({core_rstn, bus.busy, bus.cfg_ready}), 32'b010);
        e.spins = direct ? dir_exp : ground(shadow);
        e.lat   = 81 + int'(rc) + EXTRA;
        e.c0    = cyc;
        sb.push_back(e);

        if (direct) begin
            // Window sees the value present before each of its 64 sampling edges.
            repeat (16) @(posedge clk);
            #1;
            for (int k = 0; k < 64; k++) begin
                dir_out = {1'(k < 33), 1'(k < 32), 1'b0};
                @(posedge clk); #1;
            end
            dir_out = 3'b000;
        end

        if (disturb) begin
            repeat (66) @(posedge clk);
            #1;
            check_eq("run_rstn_ready", 32'({core_rstn, bus.cfg_ready}), 32'b10);
            bus.cfg_valid  = 1'b1;
            bus.cfg_addr   = 2'd0;
            bus.cfg_data   = 3'(shadow[2:0] + 3'd1);
            bus.start      = 1'b1;
            bus.run_cycles = 16'd5;
            @(posedge clk); #1;
            bus.cfg_valid = 1'b0;
            bus.start     = 1'b0;
            check_eq("wgt_frozen", 32'(core_weights), 32'(shadow));
            check_eq("busy_in_run", 32'(bus.busy), 32'd1);
        end

        t = 0;
        while (!bus.res_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.res_valid) begin
            check_eq("res_valid_timeout", 32'd0, 32'd1);
            return;
        end

        if (hold_lo > 0) begin
            snap   = bus.res_spins;
            stable = 1'b1;
            repeat (hold_lo) begin
                @(negedge clk);
                if (!bus.res_valid || bus.res_spins !== snap || !bus.busy) stable = 1'b0;
            end
            check_eq("done_hold_stable", 32'(stable), 32'd1);
        end

        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check_eq("idle_after_hs",
                 32'({bus.res_valid, bus.busy, bus.cfg_ready, core_rstn}), 32'b0010);
    endtask

    initial begin
        rst            = 1'b1;
        dir_mode       = 1'b0;
        dir_out        = 3'b000;
        shadow         = NEUTRAL;
        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = 2'd0;
        bus.cfg_data   = 3'd0;
        bus.start      = 1'b0;
        bus.run_cycles = 16'd0;
        bus.res_ready  = 1'b0;

        #12;
        check_eq("rst_weights", 32'(core_weights), 32'(NEUTRAL));
        check_eq("rst_outputs",
                 32'({core_rstn, bus.cfg_ready, bus.busy, bus.res_valid, bus.res_spins}),
                 32'b0100_000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Mixed couplings; last weight lands in the same cycle as start.
        do_write(2'd0, 3'd2);
        do_write(2'd1, 3'd4);
        do_write(2'd3, 3'd0);
        run_anneal(16'd200, 3'b000, 1'b0, 1'b0, 0, 1'b1, 2'd2, 3'd0);

        // Same weights with start/cfg attempts mid-run.
        run_anneal(16'd200, 3'b000, 1'b0, 1'b1, 0, 1'b0, 2'd0, 3'd0);

        // All couplings positive.
        do_write(2'd0, 3'd4);
        do_write(2'd1, 3'd4);
        do_write(2'd2, 3'd4);
        run_anneal(16'd200, 3'b000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 3'd0);

        // Zero-length run and vote threshold: 32 mismatches tie to 0, 33 vote 1.
        dir_mode = 1'b1;
        run_anneal(16'd0, 3'b100, 1'b1, 1'b0, 0, 1'b0, 2'd0, 3'd0);
        dir_mode = 1'b0;

        // Asynchronous reset in the middle of SAMPLE aborts the run.
        bus.run_cycles = 16'd200;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (16 + 200 + EXTRA + 20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_outputs", 32'({core_rstn, bus.res_valid, bus.busy}), 32'b000);
        check_eq("abort_weights", 32'(core_weights), 32'(NEUTRAL));
        shadow = NEUTRAL;
        #4;
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check_eq("abort_stays_idle", 32'({bus.busy, bus.res_valid, bus.cfg_ready}), 32'b001);

        // Fresh run after abort, with a stalled result consumer.
        @(posedge clk); #1;
        do_write(2'd0, 3'd0);
        do_write(2'd1, 3'd0);
        do_write(2'd2, 3'd4);
        run_anneal(16'd200, 3'b000, 1'b0, 1'b0, 50, 1'b0, 2'd0, 3'd0);

        repeat (5) @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
